// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : life_pkg
//  Purpose  : Shared constants, encodings and helpers for the Game of Life
//             double-buffered board memory.
//  Revision : 1.0 - initial release
// ============================================================================
package life_pkg;

    // Seed pattern; row r of the board takes entry r mod 4.
    localparam logic [15:0] SEED_TAB [4] = '{16'hC813, 16'h338C, 16'h33CC, 16'h6186};

    // Fill sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // What the fill sequencer writes.
    typedef enum logic [0:0] {
        FILL_CLEAR = 1'b0,
        FILL_SEED  = 1'b1
    } fill_mode_t;

    // Seed word for board row r, with bits at or above cols forced to zero.
    function automatic logic [15:0] seed_row(input int unsigned r, input int unsigned cols);
        logic [1:0]  w_idx;
        logic [15:0] w_word;
        w_idx  = 2'(r % 32'd4);
        w_word = SEED_TAB[w_idx];
        for (int unsigned i = 0; i < 16; i++) begin
            if (i >= cols) begin
                w_word[i] = 1'b0;
            end
        end
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module   : life_bank_ram
//  Purpose  : One ROWS x COLS bank of cell state. One synchronous write port,
//             one combinational read port, one registered read port.
//             Rows at or beyond ROWS read as zero and ignore writes.
//  Revision : 1.0 - initial release
// ============================================================================
module life_bank_ram #(
    parameter int COLS  = 16,
    parameter int ROWS  = 4,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data,
    input  logic [ROW_W-1:0] q_row,
    output logic [COLS-1:0]  q_data
);

    localparam logic [ROW_W:0] ROWS_V = (ROW_W + 1)'(ROWS);

    logic [COLS-1:0] r_mem [ROWS];
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic            w_q_ok;

    assign w_wr_ok = ({1'b0, wr_row} < ROWS_V);
    assign w_rd_ok = ({1'b0, rd_row} < ROWS_V);
    assign w_q_ok  = ({1'b0, q_row}  < ROWS_V);

    // Storage write; contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (wr_en && w_wr_ok) begin
            r_mem[wr_row] <= wr_data;
        end
    end

    assign rd_data = w_rd_ok ? r_mem[rd_row] : '0;

    // Registered read port, one cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data <= '0;
        end else begin
            q_data <= w_q_ok ? r_mem[q_row] : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/life_board_mem.sv
`default_nettype none
// ============================================================================
//  Module   : life_board_mem
//  Purpose  : Double-buffered Game of Life board. The current bank feeds the
//             VGA path and the neighbour selector; the selector writes the
//             other bank; a swap exchanges them. A fill sequencer clears or
//             seeds both banks after reset and on request.
//  Revision : 1.0 - initial release
// ============================================================================
module life_board_mem
    import life_pkg::*;
#(
    parameter int COLS  = 16,
    parameter int ROWS  = 4,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROW_W-1:0] vga_row,
    output logic [COLS-1:0]  vga_alive,
    input  logic [ROW_W-1:0] sel_row,
    input  logic             sel_wr_en,
    input  logic [COLS-1:0]  sel_alive_in,
    output logic [COLS-1:0]  sel_alive_out,
    input  logic             swap_req,
    input  logic             clear_req,
    input  logic             seed_req,
    output logic             busy,
    output logic             cur_bank,
    output logic [GEN_W-1:0] gen_count
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t           r_state,        w_state_nxt;
    fill_mode_t       r_fill_mode,    w_mode_nxt;
    logic [ROW_W-1:0] r_fill_row,     w_row_nxt;
    logic             r_cur_bank,     w_cur_nxt;
    logic [GEN_W-1:0] r_gen_count,    w_gen_nxt;
    logic             r_swap_pending, w_pend_nxt;
    logic             r_sel_bank;
    logic             w_fill_we;
    logic             w_sel_we;

    logic [1:0]       w_bank_we;
    logic [ROW_W-1:0] w_wr_row;
    logic [COLS-1:0]  w_wr_data;
    logic [COLS-1:0]  w_fill_word;
    logic [COLS-1:0]  w_vga_rd [2];
    logic [COLS-1:0]  w_sel_q  [2];

    // State register; reset lands in FILL/CLEAR so power-up zeroes the board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_FILL;
            r_fill_mode    <= FILL_CLEAR;
            r_fill_row     <= '0;
            r_cur_bank     <= 1'b0;
            r_gen_count    <= '0;
            r_swap_pending <= 1'b0;
            r_sel_bank     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_fill_mode    <= w_mode_nxt;
            r_fill_row     <= w_row_nxt;
            r_cur_bank     <= w_cur_nxt;
            r_gen_count    <= w_gen_nxt;
            r_swap_pending <= w_pend_nxt;
            r_sel_bank     <= r_cur_bank;
        end
    end

    // Next-state logic: fill sequencing, swap handling, selector write gating.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_fill_mode;
        w_row_nxt   = r_fill_row;
        w_cur_nxt   = r_cur_bank;
        w_gen_nxt   = r_gen_count;
        w_pend_nxt  = r_swap_pending;
        w_fill_we   = 1'b0;
        w_sel_we    = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                w_fill_we  = 1'b1;
                w_pend_nxt = r_swap_pending | swap_req;
                if (r_fill_row == LAST_ROW) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_row_nxt = r_fill_row + ROW_W'(1);
                end
            end
            ST_DONE: begin
                w_cur_nxt   = 1'b0;
                w_gen_nxt   = '0;
                w_pend_nxt  = r_swap_pending | swap_req;
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                w_sel_we = sel_wr_en;
                if (clear_req || seed_req) begin
                    // A swap arriving with a fill request waits for the fill.
                    w_state_nxt = ST_FILL;
                    w_mode_nxt  = clear_req ? FILL_CLEAR : FILL_SEED;
                    w_row_nxt   = '0;
                    w_pend_nxt  = r_swap_pending | swap_req;
                end else if (swap_req || r_swap_pending) begin
                    w_cur_nxt  = ~r_cur_bank;
                    w_gen_nxt  = r_gen_count + GEN_W'(1);
                    w_pend_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_fill_word = (r_fill_mode == FILL_SEED) ?
                         COLS'(seed_row(32'(r_fill_row), 32'(COLS))) : '0;

    // Fill writes both banks; selector writes only the bank not on display.
    assign w_bank_we[0] = w_fill_we | (w_sel_we &  r_cur_bank);
    assign w_bank_we[1] = w_fill_we | (w_sel_we & ~r_cur_bank);
    assign w_wr_row     = w_fill_we ? r_fill_row  : sel_row;
    assign w_wr_data    = w_fill_we ? w_fill_word : sel_alive_in;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        life_bank_ram #(
            .COLS  (COLS),
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (w_bank_we[b]),
            .wr_row  (w_wr_row),
            .wr_data (w_wr_data),
            .rd_row  (vga_row),
            .rd_data (w_vga_rd[b]),
            .q_row   (sel_row),
            .q_data  (w_sel_q[b])
        );
    end

    assign vga_alive     = w_vga_rd[r_cur_bank];
    assign sel_alive_out = w_sel_q[r_sel_bank];
    assign busy          = (r_state != ST_IDLE);
    assign cur_bank      = r_cur_bank;
    assign gen_count     = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_life_board_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_life_board_mem
//  Purpose  : Self-checking bench for life_board_mem: reference board model
//             compared every cycle, plus hand-computed expectations, and a
//             second instance with COLS=8, ROWS=6.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_life_board_mem;

    localparam int P_IDLE = 0;
    localparam int P_FILL = 1;
    localparam int P_DONE = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Main instance: 16 x 4
    logic [1:0]  vga_row      = '0;
    logic [15:0] vga_alive;
    logic [1:0]  sel_row      = '0;
    logic        sel_wr_en    = 1'b0;
    logic [15:0] sel_alive_in = '0;
    logic [15:0] sel_alive_out;
    logic        swap_req     = 1'b0;
    logic        clear_req    = 1'b0;
    logic        seed_req     = 1'b0;
    logic        busy;
    logic        cur_bank;
    logic [15:0] gen_count;

    // Second instance: 8 x 6
    logic [2:0]  b_vga_row      = '0;
    logic [7:0]  b_vga_alive;
    logic [2:0]  b_sel_row      = '0;
    logic        b_sel_wr_en    = 1'b0;
    logic [7:0]  b_sel_alive_in = '0;
    logic [7:0]  b_sel_alive_out;
    logic        b_swap_req     = 1'b0;
    logic        b_clear_req    = 1'b0;
    logic        b_seed_req     = 1'b0;
    logic        b_busy;
    logic        b_cur_bank;
    logic [15:0] b_gen_count;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    life_board_mem dut (
        .clk(clk), .rst_n(rst_n), .vga_row(vga_row), .vga_alive(vga_alive),
        .sel_row(sel_row), .sel_wr_en(sel_wr_en), .sel_alive_in(sel_alive_in),
        .sel_alive_out(sel_alive_out), .swap_req(swap_req), .clear_req(clear_req),
        .seed_req(seed_req), .busy(busy), .cur_bank(cur_bank), .gen_count(gen_count)
    );

    life_board_mem #(.COLS(8), .ROWS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .vga_row(b_vga_row), .vga_alive(b_vga_alive),
        .sel_row(b_sel_row), .sel_wr_en(b_sel_wr_en), .sel_alive_in(b_sel_alive_in),
        .sel_alive_out(b_sel_alive_out), .swap_req(b_swap_req), .clear_req(b_clear_req),
        .seed_req(b_seed_req), .busy(b_busy), .cur_bank(b_cur_bank), .gen_count(b_gen_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model of the 16x4 board ----------------
    function automatic logic [15:0] fill_word(input logic seed, input int r);
        if (!seed) return 16'h0000;
        case (r % 4)
            0:       return 16'hC813;
            1:       return 16'h338C;
            2:       return 16'h33CC;
            default: return 16'h6186;
        endcase
    endfunction

    logic [15:0] m_bank [2][4];
    int          m_phase     = P_FILL;
    int          m_row       = 0;
    logic        m_seed      = 1'b0;
    logic        m_cur       = 1'b0;
    logic [15:0] m_gen       = '0;
    logic        m_pend      = 1'b0;
    logic        m_known     = 1'b0;
    logic [15:0] m_sel_exp   = '0;
    logic        m_sel_valid = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase     <= P_FILL;
            m_row       <= 0;
            m_seed      <= 1'b0;
            m_cur       <= 1'b0;
            m_gen       <= '0;
            m_pend      <= 1'b0;
            m_sel_exp   <= '0;
            m_sel_valid <= 1'b1;
        end else begin
            m_sel_exp   <= m_bank[m_cur][sel_row];
            m_sel_valid <= m_known && (m_phase != P_FILL);
            case (m_phase)
                P_FILL: begin
                    m_bank[0][m_row] <= fill_word(m_seed, m_row);
                    m_bank[1][m_row] <= fill_word(m_seed, m_row);
                    if (swap_req) m_pend <= 1'b1;
                    if (m_row == 3) begin
                        m_phase <= P_DONE;
                        m_known <= 1'b1;
                    end else begin
                        m_row <= m_row + 1;
                    end
                end
                P_DONE: begin
                    m_cur   <= 1'b0;
                    m_gen   <= '0;
                    m_phase <= P_IDLE;
                    if (swap_req) m_pend <= 1'b1;
                end
                default: begin
                    if (sel_wr_en) m_bank[!m_cur][sel_row] <= sel_alive_in;
                    if (clear_req || seed_req) begin
                        m_phase <= P_FILL;
                        m_row   <= 0;
                        m_seed  <= !clear_req;
                        if (swap_req) m_pend <= 1'b1;
                    end else if (swap_req || m_pend) begin
                        m_cur  <= !m_cur;
                        m_gen  <= m_gen + 16'd1;
                        m_pend <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, (m_phase != P_IDLE));
            check("cur_bank", cur_bank, m_cur);
            check("gen_count", gen_count, m_gen);
            if (m_known) check("vga_alive", vga_alive, m_bank[m_cur][vga_row]);
            if (m_sel_valid) check("sel_alive_out", sel_alive_out, m_sel_exp);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int limit);
        for (int i = 0; i < limit && busy; i++) tick();
        check(name, busy, 1'b0);
    endtask

    task automatic b_wait_idle(input string name, input int limit);
        for (int i = 0; i < limit && b_busy; i++) tick();
        check(name, b_busy, 1'b0);
    endtask

    task automatic vga_expect(input string name, input int r, input logic [15:0] e);
        vga_row = 2'(r);
        #1;
        check(name, vga_alive, e);
    endtask

    task automatic b_vga_expect(input string name, input int r, input logic [7:0] e);
        b_vga_row = 3'(r);
        #1;
        check(name, b_vga_alive, e);
    endtask

    task automatic expect_seed_rows(input string name);
        vga_expect(name, 0, 16'hC813);
        vga_expect(name, 1, 16'h338C);
        vga_expect(name, 2, 16'h33CC);
        vga_expect(name, 3, 16'h6186);
    endtask

    task automatic expect_zero_rows(input string name);
        for (int r = 0; r < 4; r++) vga_expect(name, r, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp6 [6];
        exp6 = '{8'h13, 8'h8C, 8'hCC, 8'h86, 8'h13, 8'h8C};

        // Reset and power-up clear
        tick(); tick();
        check("rst_busy", busy, 1'b1);
        check("rst_cur_bank", cur_bank, 1'b0);
        check("rst_gen_count", gen_count, 16'd0);
        check("rst_sel_out", sel_alive_out, 16'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("pwrup_busy_done", busy, 1'b1);
        tick();
        check("pwrup_busy_idle", busy, 1'b0);
        expect_zero_rows("pwrup_zero");
        check("pwrup_gen", gen_count, 16'd0);

        // Seed
        seed_req = 1'b1; tick(); seed_req = 1'b0;
        wait_idle("seed_idle", 20);
        expect_seed_rows("seed_row");
        sel_row = 2'd2; tick();
        check("sel_row2", sel_alive_out, 16'h33CC);

        // Selector write is invisible until swap
        sel_row = 2'd1; sel_alive_in = 16'hFFFF; sel_wr_en = 1'b1; tick(); sel_wr_en = 1'b0;
        vga_expect("wr_hidden", 1, 16'h338C);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        vga_expect("wr_swapped", 1, 16'hFFFF);
        check("swap1_cur", cur_bank, 1'b1);
        check("swap1_gen", gen_count, 16'd1);

        // Write and swap in the same cycle
        sel_row = 2'd0; sel_alive_in = 16'h0001; sel_wr_en = 1'b1; swap_req = 1'b1;
        tick();
        sel_wr_en = 1'b0; swap_req = 1'b0;
        vga_expect("wr_swap_same", 0, 16'h0001);
        check("swap2_cur", cur_bank, 1'b0);
        check("swap2_gen", gen_count, 16'd2);

        // Swap requests during a fill collapse to one, executed after DONE
        seed_req = 1'b1; tick(); seed_req = 1'b0;
        swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        check("busy_no_swap", cur_bank, 1'b0);
        wait_idle("pend_idle", 20);
        check("pend_gen_zero", gen_count, 16'd0);
        tick();
        check("pend_cur", cur_bank, 1'b1);
        check("pend_gen", gen_count, 16'd1);
        expect_seed_rows("bank1_seed");
        tick();
        check("pend_single", gen_count, 16'd1);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        expect_seed_rows("bank0_seed");
        check("swap3_gen", gen_count, 16'd2);

        // Clear wins over seed
        clear_req = 1'b1; seed_req = 1'b1; tick(); clear_req = 1'b0; seed_req = 1'b0;
        wait_idle("clr_idle", 20);
        expect_zero_rows("clr_wins");

        // Reset during a seed fill restarts as a clear
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        check("pre_rst_cur", cur_bank, 1'b1);
        seed_req = 1'b1; tick(); seed_req = 1'b0; tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b1);
        check("midrst_cur", cur_bank, 1'b0);
        check("midrst_gen", gen_count, 16'd0);
        check("midrst_sel", sel_alive_out, 16'd0);
        tick();
        rst_n = 1'b1;
        wait_idle("midrst_idle", 20);
        expect_zero_rows("midrst_clear");

        // 8 x 6 instance: truncated seed and out-of-range rows
        b_wait_idle("b_idle0", 20);
        b_vga_expect("b_pwrup_zero", 5, 8'h00);
        b_seed_req = 1'b1; tick(); b_seed_req = 1'b0;
        b_wait_idle("b_seed_idle", 20);
        for (int r = 0; r < 6; r++) b_vga_expect("b_seed_row", r, exp6[r]);
        b_vga_expect("b_oor6", 6, 8'h00);
        b_vga_expect("b_oor7", 7, 8'h00);
        b_sel_row = 3'd4; tick();
        check("b_sel_row4", b_sel_alive_out, 8'h13);
        b_sel_row = 3'd6; tick();
        check("b_sel_oor", b_sel_alive_out, 8'h00);
        b_sel_row = 3'd7; b_sel_alive_in = 8'hFF; b_sel_wr_en = 1'b1; tick(); b_sel_wr_en = 1'b0;
        b_swap_req = 1'b1; tick(); b_swap_req = 1'b0;
        check("b_swap_cur", b_cur_bank, 1'b1);
        b_vga_expect("b_oor_wr_drop", 7, 8'h00);
        b_vga_expect("b_bank1_row4", 4, 8'h13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
